// File: rtl/register_load_and_reset_pkg.sv
// Shared constants and types for the parallel-load register with async clear.
// Provides the default word width, default reset word and the default word type.
package register_load_and_reset_pkg;

    localparam int REG_WIDTH_DEFAULT = 4;

    typedef logic [REG_WIDTH_DEFAULT-1:0] reg_word_t;

    localparam reg_word_t REG_RESET_VALUE_DEFAULT = '0;

endpackage : register_load_and_reset_pkg

// File: rtl/register_load_and_reset_reg_bit_cell.sv
// One storage bit: a flop with load-enable recirculation and an async active-high
// clear to a per-instance reset level.
module reg_bit_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic d_in,
    output logic q_out
);

    logic bit_d;
    logic bit_q;

    // Without load the flop recirculates its own value, so it holds across edges.
    always_comb begin
        bit_d = bit_q;
        if (load) begin
            bit_d = d_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_q <= RESET_BIT;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q_out = bit_q;

endmodule : reg_bit_cell

// File: rtl/register_load_and_reset.sv
// Parameterised parallel-load register with load enable and asynchronous clear.
// Define REGISTER_LOAD_AND_RESET_PARITY_EN to add a registered even-parity output q_parity.
module register_load_and_reset
    import register_load_and_reset_pkg::*;
#(
    parameter int               WIDTH       = REG_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET_VALUE_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q_out
`ifdef REGISTER_LOAD_AND_RESET_PARITY_EN
    ,
    output logic             q_parity
`endif
);

    // Each bit gets its own reset level, so any RESET_VALUE pattern is supported.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        reg_bit_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .d_in  (data_in[i]),
            .q_out (q_out[i])
        );
    end

`ifdef REGISTER_LOAD_AND_RESET_PARITY_EN
    localparam logic RESET_PARITY = ^RESET_VALUE;

    logic data_parity;

    // Parity is taken from the incoming word so it lands on the same edge as q_out.
    always_comb begin
        data_parity = ^data_in;
    end

    reg_bit_cell #(
        .RESET_BIT (RESET_PARITY)
    ) u_parity (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d_in  (data_parity),
        .q_out (q_parity)
    );
`endif

endmodule : register_load_and_reset

// File: tb/tb_register_load_and_reset.sv
// Self-checking bench for register_load_and_reset: directed sequence plus randomized
// load/data/reset traffic checked against a word-level reference model.
module tb_register_load_and_reset;

    localparam int       W  = 4;
    localparam logic [W-1:0] RV = '0;

    logic         clk     = 1'b0;
    logic         reset   = 1'b0;
    logic         load    = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] q_out;
`ifdef REGISTER_LOAD_AND_RESET_PARITY_EN
    logic         q_parity;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: the word the register should hold right now.
    logic [W-1:0] model_q;

    register_load_and_reset #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data_in  (data_in),
        .q_out    (q_out)
`ifdef REGISTER_LOAD_AND_RESET_PARITY_EN
        ,
        .q_parity (q_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput(tag, 64'(q_out), 64'(model_q));
`ifdef REGISTER_LOAD_AND_RESET_PARITY_EN
        checkOutput({tag, "_par"}, 64'(q_parity), 64'(^model_q));
`endif
    endtask

    task automatic applyStimulus(input logic ld, input logic [W-1:0] d);
        @(negedge clk);
        load    = ld;
        data_in = d;
    endtask

    // The model captures data_in on an edge only when reset is low and load is high.
    task automatic clockEdge();
        @(posedge clk);
        if (!reset && load) begin
            model_q = data_in;
        end
        #1;
    endtask

    task automatic assertResetMidCycle();
        @(negedge clk);
        #2;
        reset   = 1'b1;
        model_q = RV;
        #1;
    endtask

    initial begin
        model_q = RV;

        // Reset with data pending and no load.
        #1;
        reset   = 1'b1;
        load    = 1'b0;
        data_in = 4'b0011;
        #1;
        checkOutput("rst_init", 64'(q_out), 64'(4'b0000));
        clockEdge();
        checkOutput("rst_hold0", 64'(q_out), 64'(4'b0000));
        clockEdge();
        checkOutput("rst_hold1", 64'(q_out), 64'(4'b0000));

        // Release with load=1 captures on the next edge.
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b1;
        clockEdge();
        checkOutput("first_load", 64'(q_out), 64'(4'b0011));

        // Mid-cycle data change has no effect until the edge.
        applyStimulus(1'b1, 4'b1100);
        #1;
        checkOutput("mid_cycle", 64'(q_out), 64'(4'b0011));
        clockEdge();
        checkOutput("second_load", 64'(q_out), 64'(4'b1100));

        // Hold across several edges.
        applyStimulus(1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            clockEdge();
            checkOutput("hold", 64'(q_out), 64'(4'b1100));
        end

        // Async clear between edges, then reset dominates load.
        assertResetMidCycle();
        checkOutput("async_clr", 64'(q_out), 64'(4'b0000));
        load    = 1'b1;
        data_in = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            clockEdge();
            checkOutput("rst_over_load", 64'(q_out), 64'(4'b0000));
        end

        // Release just after an edge with load=1.
        @(posedge clk);
        #1;
        reset   = 1'b0;
        load    = 1'b1;
        data_in = 4'b1010;
        clockEdge();
        checkOutput("release_load", 64'(q_out), 64'(4'b1010));

        // Same release with load=0 keeps the reset value.
        assertResetMidCycle();
        checkOutput("async_clr2", 64'(q_out), 64'(4'b0000));
        @(posedge clk);
        #1;
        reset   = 1'b0;
        load    = 1'b0;
        data_in = 4'b1010;
        clockEdge();
        checkOutput("release_noload", 64'(q_out), 64'(4'b0000));

`ifdef REGISTER_LOAD_AND_RESET_PARITY_EN
        applyStimulus(1'b1, 4'b0111);
        clockEdge();
        checkOutput("par_0111", 64'(q_parity), 64'(1'b1));
        applyStimulus(1'b1, 4'b0011);
        clockEdge();
        checkOutput("par_0011", 64'(q_parity), 64'(1'b0));
        applyStimulus(1'b1, 4'b0111);
        clockEdge();
        checkOutput("par_reload", 64'(q_parity), 64'(1'b1));
        assertResetMidCycle();
        checkOutput("par_rst", 64'(q_parity), 64'(1'b0));
        @(negedge clk);
        reset = 1'b0;
`endif

        // Randomized traffic: loads, holds, mid-cycle data glitches and async resets.
        model_q = q_out === RV ? RV : model_q;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            load    = 1'($urandom_range(0, 1));
            data_in = W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                #2;
                data_in = W'($urandom);
            end
            if (reset && $urandom_range(0, 2) == 0) begin
                reset = 1'b0;
            end else if (!reset && $urandom_range(0, 24) == 0) begin
                #1;
                reset   = 1'b1;
                model_q = RV;
                #1;
                checkState("rnd_async");
            end
            clockEdge();
            checkState("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_load_and_reset

// File: doc/register_load_and_reset.md
Name: register_load_and_reset

Overview:
- Parameterised parallel-load register with load enable and asynchronous clear.
- Captures data_in on a rising clock edge when load is asserted; otherwise holds its value.
- Used as a general-purpose storage element, e.g. operand or state holding in datapaths.
- Reset forces the stored word to a constant value immediately, independent of the clock.

Parameters:
- WIDTH, default 4: data width in bits; legal range 1..64.
- RESET_VALUE, default all-zeros (WIDTH bits): value loaded into q_out during reset.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  load enable; sampled on the rising edge of clk.
- data_in  input  WIDTH  parallel data to capture.
- q_out  output  WIDTH  registered stored value.

Interface rule: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset asserted:
  - q_out = RESET_VALUE immediately (asynchronous, no clock needed).
  - q_out is held at RESET_VALUE for as long as reset stays high, regardless of load and data_in.
- Reset deasserted, rising clk edge:
  - load=1: q_out <= data_in as sampled at that edge. Latency is 1 edge; the new value is visible after the edge.
  - load=0: q_out holds its previous value.
- Changes on data_in or load between edges have no effect on q_out.
- q_out is driven only by flops; there is no combinational path from data_in to q_out.
- Reset has priority over load on every edge.
- Reset mid-operation: an in-progress hold or load is abandoned and the output clears at once.
- First edge after reset release:
  - Loads data_in if load=1.
  - Otherwise q_out stays at RESET_VALUE.
- Back-to-back loads on consecutive edges each capture the current data_in. There is no handshake or busy state.
- WIDTH=1 behaves identically with single-bit buses.

Optional Feature:
- Macro: REGISTER_LOAD_AND_RESET_PARITY_EN.
- Defined:
  - Adds output port q_parity (output, 1 bit).
  - q_parity is the registered even parity (XOR reduction) of the stored word.
  - It updates on the same edge as q_out, using the parity of data_in when load=1.
  - It holds when load=0.
  - It resets asynchronously to the parity of RESET_VALUE, which is 0 for the default.
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package register_load_and_reset_pkg contains:
  - Default width constant REG_WIDTH_DEFAULT=4.
  - Reset-value constant REG_RESET_VALUE_DEFAULT='0.
  - Typedef for the default data word.
- One sub-module, reg_bit_cell:
  - A single flop with async active-high reset, per-bit reset value and load-enable mux.
  - Instantiated WIDTH times via generate.
  - The parity flop, when enabled, is a further instance.

Test Plan:
- Reset and initial load:
  - Assert reset=1, load=0, data_in=0011, then toggle clk -> q_out=0000 throughout.
  - Release reset with load=1 -> q_out=0011 after the next rising edge.
- Consecutive loads: load=1, change data_in to 1100 mid-cycle -> q_out stays 0011 until the next edge, then becomes 1100.
- Hold: load=0, change data_in to 0000 and run several edges -> q_out remains 1100.
- Asynchronous reset mid-operation:
  - With q_out=1100, raise reset between clock edges -> q_out=0000 immediately, before any edge.
  - Hold reset with load=1, data_in=1111 over edges -> q_out stays 0000.
- Reset priority on release:
  - Deassert reset just after an edge with load=1, data_in=1010 -> q_out=1010 on the following edge.
  - Repeat with load=0 -> q_out stays 0000.
- Parity (macro defined, WIDTH=4):
  - Load 0111 -> q_parity=1.
  - Load 0011 -> q_parity=0.
  - Assert reset -> q_parity=0 immediately.
